// File: rtl/solve_cooling_euler_step.sv
// Euler-update stage of the Newton-cooling solver: T[n+1] = T[n] - round(kdt*(T[n]-Tamb)).
// Feeds an external pipelined multiplier and streams one rounded, saturated sample per step.
module solve_cooling_euler_step #(
    parameter int T_W     = 32,
    parameter int FRAC    = 16,
    parameter int PROD_W  = 48,
    parameter int MUL_LAT = 1,
    parameter int STEP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [T_W-1:0]    t0,
    input  logic [T_W-1:0]    t_amb,
    input  logic [31:0]       kdt,
    input  logic [STEP_W-1:0] n_steps,
    output logic              mul_ce,
    output logic [T_W:0]      mul_din0,
    output logic [31:0]       mul_din1,
    input  logic [PROD_W-1:0] mul_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [T_W-1:0]    out_data,
    output logic [STEP_W-1:0] out_idx,
    output logic              busy,
    output logic              done,
    output logic              sat
);
    localparam int LAT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int W_W   = PROD_W + 2;
    localparam logic signed [W_W-1:0]  T_MAX = {{(W_W-T_W+1){1'b0}}, {(T_W-1){1'b1}}};
    localparam logic signed [W_W-1:0]  T_MIN = {{(W_W-T_W+1){1'b1}}, {(T_W-1){1'b0}}};
    localparam logic signed [PROD_W:0] HALF  = (PROD_W+1)'(1) << (FRAC-1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_UPDATE, S_EMIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [T_W-1:0]      t_q, t_d;
    logic [T_W-1:0]      t_amb_q, t_amb_d;
    logic [T_W:0]        din0_q, din0_d;
    logic [31:0]         din1_q, din1_d;
    logic [STEP_W-1:0]   n_q, n_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [T_W-1:0]      out_data_q, out_data_d;
    logic [STEP_W-1:0]   out_idx_q, out_idx_d;
    logic                sat_q, sat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic signed [PROD_W:0] rounded, delta;
    logic signed [W_W-1:0]  t_wide;
    logic [T_W-1:0]         t_sat;
    logic                   clamp;

    // Exact (T_W+1)-bit difference of two sign-extended temperatures.
    function automatic logic [T_W:0] diff_of(input logic [T_W-1:0] a, input logic [T_W-1:0] b);
        return {a[T_W-1], a} - {b[T_W-1], b};
    endfunction

    // Round half up, then subtract in a width that cannot overflow before clamping.
    always_comb begin
        rounded = $signed({mul_dout[PROD_W-1], mul_dout}) + HALF;
        delta   = rounded >>> FRAC;
        t_wide  = $signed({{(W_W-T_W){t_q[T_W-1]}}, t_q}) - $signed({delta[PROD_W], delta});
        clamp   = 1'b1;
        if (t_wide > T_MAX) begin
            t_sat = {1'b0, {(T_W-1){1'b1}}};
        end else if (t_wide < T_MIN) begin
            t_sat = {1'b1, {(T_W-1){1'b0}}};
        end else begin
            t_sat = t_wide[T_W-1:0];
            clamp = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        t_d        = t_q;
        t_amb_d    = t_amb_q;
        din0_d     = din0_q;
        din1_d     = din1_q;
        n_d        = n_q;
        step_d     = step_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        sat_d      = sat_q;
        lat_d      = lat_q;
        mul_ce     = 1'b0;
        out_valid  = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    t_d     = t0;
                    t_amb_d = t_amb;
                    din0_d  = diff_of(t0, t_amb);
                    din1_d  = kdt;
                    n_d     = n_steps;
                    step_d  = '0;
                    sat_d   = 1'b0;
                    lat_d   = '0;
                    state_d = (n_steps == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_ce = 1'b1;
                if (lat_q == LAT_W'(MUL_LAT-1)) begin
                    state_d = S_UPDATE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_UPDATE: begin
                t_d        = t_sat;
                out_data_d = t_sat;
                out_idx_d  = step_q;
                sat_d      = sat_q | clamp;
                din0_d     = diff_of(t_sat, t_amb_q);
                state_d    = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (step_q == n_q - STEP_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        step_d  = step_q + STEP_W'(1);
                        lat_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything, including a handshake in the same cycle.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            t_amb_q    <= '0;
            din0_q     <= '0;
            din1_q     <= '0;
            n_q        <= '0;
            step_q     <= '0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            sat_q      <= 1'b0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            t_amb_q    <= t_amb_d;
            din0_q     <= din0_d;
            din1_q     <= din1_d;
            n_q        <= n_d;
            step_q     <= step_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            sat_q      <= sat_d;
            lat_q      <= lat_d;
        end
    end

    assign mul_din0 = din0_q;
    assign mul_din1 = din1_q;
    assign out_data = out_data_q;
    assign out_idx  = out_idx_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_solve_cooling_euler_step.sv
// Directed bench for solve_cooling_euler_step: arithmetic model plus scoreboard of expected samples,
// a 33s x 32s -> 48 one-stage multiplier, and cycle-level checks of the control behaviour.
module tb_solve_cooling_euler_step;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [31:0] t0, t_amb, kdt;
    logic [15:0] n_steps;
    logic        mul_ce;
    logic [32:0] mul_din0;
    logic [31:0] mul_din1;
    logic [47:0] mul_dout;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [15:0] out_idx;
    logic        busy, done, sat;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] idx;
    } sample_t;
    sample_t exp_q[$];

    always #5 clk = ~clk;

    solve_cooling_euler_step dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .t0(t0), .t_amb(t_amb), .kdt(kdt), .n_steps(n_steps),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done), .sat(sat)
    );

    // One-stage multiplier: low 48 bits of the signed product, captured while mul_ce is high.
    logic signed [64:0] mul_a, mul_b, mul_full;
    always_comb begin
        mul_a    = $signed(mul_din0);
        mul_b    = $signed(mul_din1);
        mul_full = mul_a * mul_b;
    end
    always @(posedge clk or posedge reset) begin
        if (reset)       mul_dout <= '0;
        else if (mul_ce) mul_dout <= mul_full[47:0];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One Euler step with plain integer arithmetic.
    function automatic void model_step(input logic [31:0] t, input logic [31:0] amb,
                                       input logic [31:0] k, output logic [31:0] tn,
                                       output bit clamped);
        longint d, p, dl, tw;
        d  = longint'($signed(t)) - longint'($signed(amb));
        p  = d * longint'($signed(k));
        p  = (p <<< 16) >>> 16;
        dl = (p + 32768) >>> 16;
        tw = longint'($signed(t)) - dl;
        clamped = 1'b1;
        if (tw > 64'sd2147483647)       tn = 32'h7FFF_FFFF;
        else if (tw < -64'sd2147483648) tn = 32'h8000_0000;
        else begin
            tn = tw[31:0];
            clamped = 1'b0;
        end
    endfunction

    task automatic load_model(input logic [31:0] t0_v, input logic [31:0] amb_v,
                              input logic [31:0] k_v, input int n, output bit sat_exp);
        logic [31:0] t, tn;
        bit cl;
        t = t0_v;
        sat_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
            model_step(t, amb_v, k_v, tn, cl);
            exp_q.push_back('{tn, 16'(i)});
            sat_exp |= cl;
            t = tn;
        end
    endtask

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    sample_t     exp_s;
    logic        hold_v = 1'b0;
    logic [31:0] hold_data;
    logic [15:0] hold_idx;
    always @(negedge clk) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (out_valid && hold_v) begin
                check("hold_data", out_data, hold_data);
                check("hold_idx", out_idx, hold_idx);
            end
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", out_data, 64'hDEAD_0000_0000);
                end else begin
                    exp_s = exp_q.pop_front();
                    check("sample_data", out_data, exp_s.data);
                    check("sample_idx", out_idx, exp_s.idx);
                end
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v    = 1'b1;
                hold_data = out_data;
                hold_idx  = out_idx;
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_mul_ce"}, mul_ce, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sat"}, sat, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_din0"}, mul_din0, 0);
        check({tag, "_din1"}, mul_din1, 0);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b1;
        end
    endtask

    // Full run; stall_mode holds out_ready low for 5 cycles of every EMIT.
    task automatic run(input string tag, input logic [31:0] t0_v, input logic [31:0] amb_v,
                       input logic [31:0] k_v, input int n, input bit stall_mode);
        bit sat_exp;
        int done0, first_valid, done_at, stall;
        load_model(t0_v, amb_v, k_v, n, sat_exp);
        done0 = done_cnt; first_valid = -1; done_at = -1; stall = 0;
        t0 = t0_v; t_amb = amb_v; kdt = k_v; n_steps = 16'(n);
        out_ready = !stall_mode;
        start = 1'b1;
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid && first_valid < 0) first_valid = c;
            if (done) done_at = c;
            if (stall_mode) begin
                if (out_ready) out_ready = 1'b0;
                else if (out_valid) begin
                    if (stall == 5) begin
                        out_ready = 1'b1;
                        stall = 0;
                    end else stall++;
                end
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        check({tag, "_done_seen"}, done_at >= 0, 1);
        if (!stall_mode && n > 0) begin
            check({tag, "_first_valid_cycle"}, first_valid, 3);
            check({tag, "_done_cycle"}, done_at, 3 * n + 1);
        end
        check({tag, "_done_pulses"}, done_cnt - done0, 1);
        check({tag, "_samples_left"}, exp_q.size(), 0);
        check({tag, "_sat"}, sat, sat_exp);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    logic [31:0] m_t;
    bit          m_cl, ok, dummy_sat;
    int          done0;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        t0 = '0; t_amb = '0; kdt = '0; n_steps = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Hand-computed pins for the model itself.
        model_step(32'h0064_0000, 32'h0014_0000, 32'h0000_8000, m_t, m_cl);
        check("model_step1", m_t, 32'h003C_0000);
        model_step(m_t, 32'h0014_0000, 32'h0000_8000, m_t, m_cl);
        check("model_step2", m_t, 32'h0028_0000);
        model_step(m_t, 32'h0014_0000, 32'h0000_8000, m_t, m_cl);
        check("model_step3", m_t, 32'h001E_0000);
        model_step(32'h0014_0001, 32'h0014_0000, 32'h0000_8000, m_t, m_cl);
        check("model_round_up", m_t, 32'h0014_0000);
        model_step(32'h7FFF_0000, 32'h7FFE_0000, 32'hFFFF_0000, m_t, m_cl);
        check("model_pos_clamp", {m_t, 31'd0, m_cl}, {32'h7FFF_FFFF, 32'd1});
        // Here diff*kdt = -(2^48-2^32) wraps to +2^32 in 48 bits: a plain -1.0 step.
        model_step(32'h7FFF_0000, 32'h8000_0000, 32'hFFFF_0000, m_t, m_cl);
        check("model_wrap", {m_t, 31'd0, m_cl}, {32'h7FFE_0000, 32'd0});

        run("basic", 32'h0064_0000, 32'h0014_0000, 32'h0000_8000, 3, 1'b0);
        run("stall", 32'h0064_0000, 32'h0014_0000, 32'h0000_8000, 3, 1'b1);

        // n_steps == 0: straight to DONE, which is the only busy cycle.
        done0 = done_cnt;
        n_steps = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("n0_done", done, 1);
        check("n0_busy", busy, 1);
        check("n0_valid", out_valid, 0);
        @(posedge clk); #1;
        check("n0_done_drop", done, 0);
        check("n0_busy_drop", busy, 0);
        @(posedge clk); #1;
        check("n0_done_pulses", done_cnt - done0, 1);

        run("sat_pos", 32'h7FFF_0000, 32'h7FFE_0000, 32'hFFFF_0000, 1, 1'b0);
        run("sat_wrap", 32'h7FFF_0000, 32'h8000_0000, 32'hFFFF_0000, 1, 1'b0);
        run("sat_neg", 32'h8000_0000, 32'h8001_0000, 32'hFFFF_0000, 2, 1'b0);
        run("round_up", 32'h0014_0001, 32'h0014_0000, 32'h0000_8000, 1, 1'b0);
        run("round_neg", 32'h0013_FFFF, 32'h0014_0000, 32'h0000_8000, 2, 1'b0);

        // Abort in the second EMIT, with a same-cycle handshake that must be ignored.
        done0 = done_cnt;
        load_model(32'h0064_0000, 32'h0014_0000, 32'h0000_8000, 3, dummy_sat);
        t0 = 32'h0064_0000; t_amb = 32'h0014_0000; kdt = 32'h0000_8000; n_steps = 16'd3;
        out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(20, ok);
        check("abort_first_valid", ok, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        wait_valid(20, ok);
        check("abort_second_valid", ok, 1);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; out_ready = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_mul_ce", mul_ce, 0);
        check("abort_left", exp_q.size(), 2);
        @(posedge clk); #1;
        check("abort_no_done", done_cnt - done0, 0);
        exp_q.delete();

        // Reset in the middle of the ISSUE cycle of a new run.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("pre_reset_issue", mul_ce, 1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;

        run("fresh", 32'h0064_0000, 32'h0014_0000, 32'h0000_8000, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
